m_stage_merge_n: RTL and testbench

//  Clocked, parametrised N-way merge stage for the DDP packet pipeline. Each of N_IN

---
 rtl/m_stage_merge_n.sv | 143 ++++++++++++++
 tb/tb_m_stage_merge_n.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_stage_merge_n.sv
// ---------------------------------------------------------------------------
// m_stage_merge_n
// N-way merge stage for the DDP packet pipeline. Each input channel owns a
// one-packet latch. An arbiter moves at most one latched packet per cycle into
// a single output register, which feeds the next stage over Send/Ack.
// Arbitration is fixed priority (lowest index wins) or round-robin.
//
// Ports
//   CLK         clock, all state changes on the rising edge
//   MR_N        synchronous active-low reset
//   Send_in     per-channel request, data valid on the matching PACKET_IN slice
//   PACKET_IN   channel i occupies bits [i*PW +: PW]
//   Ack_out     per-channel accept (registered, equals ~full once out of reset)
//   Send_out    output register holds a valid packet
//   Ack_in      downstream accept
//   PACKET_OUT  output register data
//   SRC_OUT     channel index of the packet held in PACKET_OUT
// ---------------------------------------------------------------------------
module m_stage_merge_n #(
    parameter  int N_IN     = 2,
    parameter  int PW       = 32,
    parameter  int ARB_MODE = 0,
    localparam int SW       = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic               CLK,
    input  logic               MR_N,
    input  logic [N_IN-1:0]    Send_in,
    input  logic [N_IN*PW-1:0] PACKET_IN,
    output logic [N_IN-1:0]    Ack_out,
    output logic               Send_out,
    input  logic               Ack_in,
    output logic [PW-1:0]      PACKET_OUT,
    output logic [SW-1:0]      SRC_OUT
);

    logic [N_IN-1:0] full_q;
    logic [N_IN-1:0] full_d;
    logic [N_IN-1:0] ack_q;
    logic [N_IN-1:0] take;
    logic [PW-1:0]   latch_q [N_IN];

    logic            send_q;
    logic            send_d;
    logic [PW-1:0]   pkt_q;
    logic [PW-1:0]   pkt_d;
    logic [SW-1:0]   src_q;
    logic [SW-1:0]   src_d;
    logic [SW-1:0]   rr_q;
    logic [SW-1:0]   rr_d;

    logic            load_ok;
    logic            grant_vld;
    logic [SW-1:0]   grant_idx;

    // The output register can take a new packet when it is empty or is being
    // drained on this same edge.
    assign load_ok = ~send_q | Ack_in;

    // Arbitration over latched packets only; Send_in never participates, so a
    // packet always spends at least one cycle in its latch.
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        if (load_ok) begin
            for (int k = 0; k < N_IN; k++) begin
                idx = (ARB_MODE == 1) ? int'(rr_q) + k : k;
                if (idx >= N_IN) begin
                    idx = idx - N_IN;
                end
                if (!grant_vld && full_q[idx[SW-1:0]]) begin
                    grant_vld = 1'b1;
                    grant_idx = idx[SW-1:0];
                end
            end
        end
    end

    // Per-channel input latches. Ack is ~full, so a channel that is granted
    // this cycle cannot also capture this cycle.
    genvar gi;
    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_ch
            assign take[gi]   = Send_in[gi] & ack_q[gi];
            assign full_d[gi] = take[gi] |
                                (full_q[gi] & ~(grant_vld && (grant_idx == SW'(gi))));

            always_ff @(posedge CLK) begin
                if (!MR_N) begin
                    latch_q[gi] <= '0;
                end else if (take[gi]) begin
                    latch_q[gi] <= PACKET_IN[gi*PW +: PW];
                end
            end
        end
    endgenerate

    // Output register and round-robin pointer next state.
    always_comb begin
        send_d = send_q;
        pkt_d  = pkt_q;
        src_d  = src_q;
        rr_d   = rr_q;
        if (grant_vld) begin
            send_d = 1'b1;
            pkt_d  = latch_q[grant_idx];
            src_d  = grant_idx;
            if (ARB_MODE == 1) begin
                rr_d = (grant_idx == SW'(N_IN - 1)) ? '0 : grant_idx + SW'(1);
            end
        end else if (load_ok) begin
            // Nothing to load while draining or empty: go idle, keep data.
            send_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!MR_N) begin
            full_q <= '0;
            ack_q  <= '0;
            send_q <= 1'b0;
            pkt_q  <= '0;
            src_q  <= '0;
            rr_q   <= '0;
        end else begin
            full_q <= full_d;
            // Registered from next-state fullness so Ack_out tracks ~full
            // without any combinational path from the inputs.
            ack_q  <= ~full_d;
            send_q <= send_d;
            pkt_q  <= pkt_d;
            src_q  <= src_d;
            rr_q   <= rr_d;
        end
    end

    assign Ack_out    = ack_q;
    assign Send_out   = send_q;
    assign PACKET_OUT = pkt_q;
    assign SRC_OUT    = src_q;

endmodule

// File: tb/tb_m_stage_merge_n.sv
module tb_m_stage_merge_n;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         mr_n;
    logic [3:0]   send_in;
    logic [127:0] pkt_in;
    logic         ack_in;

    logic [3:0]   ack_fp;
    logic         send_fp;
    logic [31:0]  pout_fp;
    logic [1:0]   src_fp;

    logic [2:0]   ack_rr;
    logic         send_rr;
    logic [31:0]  pout_rr;
    logic [1:0]   src_rr;

    int n_checks = 0;
    int n_errors = 0;

    // Fixed priority, 4 channels
    m_stage_merge_n #(.N_IN(4), .PW(32), .ARB_MODE(0)) u_fp (
        .CLK        (clk),
        .MR_N       (mr_n),
        .Send_in    (send_in),
        .PACKET_IN  (pkt_in),
        .Ack_out    (ack_fp),
        .Send_out   (send_fp),
        .Ack_in     (ack_in),
        .PACKET_OUT (pout_fp),
        .SRC_OUT    (src_fp)
    );

    // Round-robin, 3 channels (non-power-of-two wrap)
    m_stage_merge_n #(.N_IN(3), .PW(32), .ARB_MODE(1)) u_rr (
        .CLK        (clk),
        .MR_N       (mr_n),
        .Send_in    (send_in[2:0]),
        .PACKET_IN  (pkt_in[95:0]),
        .Ack_out    (ack_rr),
        .Send_out   (send_rr),
        .Ack_in     (ack_in),
        .PACKET_OUT (pout_rr),
        .SRC_OUT    (src_rr)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (index 0 = fixed, 1 = round-robin) ----
    logic        m_full [2][4];
    logic [31:0] m_lat  [2][4];
    logic        m_ack  [2][4];
    logic        m_send [2];
    logic [31:0] m_pkt  [2];
    int          m_src  [2];
    int          m_rr   [2];
    logic [31:0] sbq    [8][$];   // accepted packets, queue m*4+channel

    function automatic int nch(input int m);
        return (m == 0) ? 4 : 3;
    endfunction

    function automatic logic [3:0] exp_ack(input int m);
        logic [3:0] v = '0;
        for (int i = 0; i < nch(m); i++) v[i] = m_ack[m][i];
        return v;
    endfunction

    task automatic model_step(input int m);
        int n = nch(m);
        int g = -1;
        bit load;
        bit acc [4];
        if (!mr_n) begin
            for (int i = 0; i < 4; i++) begin
                m_full[m][i] = 1'b0;
                m_lat[m][i]  = '0;
                m_ack[m][i]  = 1'b0;
                sbq[m*4+i].delete();
            end
            m_send[m] = 1'b0;
            m_pkt[m]  = '0;
            m_src[m]  = 0;
            m_rr[m]   = 0;
            return;
        end
        load = !m_send[m] || ack_in;
        if (load) begin
            for (int k = 0; k < n; k++) begin
                int idx = (m == 1) ? (m_rr[m] + k) % n : k;
                if (g < 0 && m_full[m][idx]) g = idx;
            end
        end
        for (int i = 0; i < 4; i++) acc[i] = (i < n) && send_in[i] && m_ack[m][i];
        if (g >= 0) begin
            m_send[m]    = 1'b1;
            m_pkt[m]     = m_lat[m][g];
            m_src[m]     = g;
            m_full[m][g] = 1'b0;
            if (m == 1) m_rr[m] = (g + 1) % n;
        end else if (load) begin
            m_send[m] = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            if (acc[i]) begin
                m_full[m][i] = 1'b1;
                m_lat[m][i]  = pkt_in[i*32 +: 32];
                sbq[m*4+i].push_back(pkt_in[i*32 +: 32]);
            end
            m_ack[m][i] = !m_full[m][i];
        end
    endtask

    // Output transfer seen on the DUT before the edge: check against the
    // per-channel accepted order.
    task automatic sb_pop(input int m, input logic dsend, input logic [31:0] dpkt, input logic [1:0] dsrc);
        int q;
        logic [31:0] e;
        if (mr_n && dsend && ack_in) begin
            q = m*4 + int'(dsrc);
            chk(m == 0 ? "fp_sb_nonempty" : "rr_sb_nonempty", 64'(sbq[q].size() > 0), 64'd1);
            if (sbq[q].size() > 0) begin
                e = sbq[q].pop_front();
                chk(m == 0 ? "fp_sb_data" : "rr_sb_data", dpkt, e);
                $display("dut%0d out src=%0d data=%08h", m, dsrc, dpkt);
            end
        end
    endtask

    task automatic check_all();
        chk("fp_ack",  ack_fp,  exp_ack(0));
        chk("fp_send", send_fp, m_send[0]);
        chk("fp_pkt",  pout_fp, m_pkt[0]);
        chk("fp_src",  src_fp,  m_src[0]);
        chk("rr_ack",  ack_rr,  exp_ack(1));
        chk("rr_send", send_rr, m_send[1]);
        chk("rr_pkt",  pout_rr, m_pkt[1]);
        chk("rr_src",  src_rr,  m_src[1]);
    endtask

    task automatic tick();
        sb_pop(0, send_fp, pout_fp, src_fp);
        sb_pop(1, send_rr, pout_rr, src_rr);
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_all();
    endtask

    task automatic rand_data();
        pkt_in = {$urandom, $urandom, $urandom, $urandom};
    endtask

    logic [31:0] held_fp;
    logic [1:0]  held_src;

    initial begin
        mr_n    = 1'b0;
        send_in = 4'hF;
        ack_in  = 1'b1;
        rand_data();

        // T1: reset with requests asserted
        repeat (2) tick();
        chk("t1_ack0",  ack_fp, 4'h0);
        chk("t1_send0", send_fp, 1'b0);
        chk("t1_pkt0",  pout_fp, 32'h0);
        mr_n    = 1'b1;
        send_in = 4'h0;
        tick();
        chk("t1_ack1", ack_fp, 4'hF);
        repeat (3) tick();
        chk("t1_nopkt", send_fp, 1'b0);

        // T2: single packet on channel 1
        pkt_in[63:32] = 32'hA5A5_0001;
        send_in = 4'b0010;
        tick();
        send_in = 4'h0;
        tick();
        chk("t2_send", send_fp, 1'b1);
        chk("t2_pkt",  pout_fp, 32'hA5A5_0001);
        chk("t2_src",  src_fp,  2'd1);
        tick();
        chk("t2_once", send_fp, 1'b0);
        repeat (2) tick();

        // T3: all channels latched together, fixed priority order 0..3
        rand_data();
        send_in = 4'hF;
        tick();
        send_in = 4'h0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t3_src", src_fp, 64'(k));
        end
        repeat (3) tick();

        // T4: two channels streaming continuously
        send_in = 4'b0011;
        for (int k = 0; k < 16; k++) begin
            rand_data();
            tick();
        end
        send_in = 4'h0;
        repeat (4) tick();

        // T5: backpressure with all latches full
        ack_in  = 1'b0;
        send_in = 4'hF;
        for (int k = 0; k < 3; k++) begin
            rand_data();
            tick();
        end
        send_in  = 4'h0;
        held_fp  = pout_fp;
        held_src = src_fp;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t5_stable_pkt", pout_fp, held_fp);
            chk("t5_stable_src", src_fp, held_src);
            chk("t5_ack0", ack_fp, 4'h0);
        end
        ack_in = 1'b1;
        repeat (8) tick();
        for (int i = 0; i < 8; i++) chk("t5_drained", 64'(sbq[i].size()), 64'd0);

        // T6: reset while output valid and latches full
        ack_in  = 1'b0;
        send_in = 4'hF;
        for (int k = 0; k < 3; k++) begin
            rand_data();
            tick();
        end
        send_in = 4'h0;
        mr_n = 1'b0;
        tick();
        chk("t6_send0", send_fp, 1'b0);
        chk("t6_rr_send0", send_rr, 1'b0);
        mr_n   = 1'b1;
        ack_in = 1'b1;
        repeat (4) tick();
        chk("t6_none", send_fp, 1'b0);

        // Random traffic with occasional reset
        for (int k = 0; k < 800; k++) begin
            mr_n    = ($urandom_range(0, 99) != 0);
            send_in = 4'($urandom);
            ack_in  = ($urandom_range(0, 3) != 0);
            rand_data();
            tick();
        end
        mr_n    = 1'b1;
        send_in = 4'h0;
        ack_in  = 1'b1;
        repeat (10) tick();
        for (int i = 0; i < 8; i++) chk("final_drained", 64'(sbq[i].size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
